// File: rtl/modulo_controlador_bandeja_rolhas_pkg.sv
// modulo_controlador_bandeja_rolhas_pkg: shared state encoding and tray level defaults
package modulo_controlador_bandeja_rolhas_pkg;
   typedef enum logic [1:0] {IDLE = 2'b00, FILL = 2'b01, LOAD = 2'b10, HOLD = 2'b11} estado_t;
   localparam int MIN_LVL_DEF  = 5;
   localparam int AUTO_QTY_DEF = 20;
   localparam int MAX_LVL_DEF  = 99;
endpackage

// File: rtl/modulo_controlador_bandeja_rolhas_if.sv
// modulo_controlador_bandeja_rolhas_if: operator load request/response handshake
interface modulo_controlador_bandeja_rolhas_if;
   logic       op_req;
   logic [6:0] op_qty;
   logic       op_ack;
   logic       op_nack;
   modport master (output op_req, op_qty, input op_ack, op_nack);
   modport slave (input op_req, op_qty, output op_ack, op_nack);
endinterface

// File: rtl/modulo_verificador_capacidade_rolhas.sv
// modulo_verificador_capacidade_rolhas: 8-bit tray load adder with capacity overflow flag
module modulo_verificador_capacidade_rolhas
   import modulo_controlador_bandeja_rolhas_pkg::*;
#(
   parameter int MAX_LVL = MAX_LVL_DEF
) (
   input  logic [6:0] count,
   input  logic [6:0] op_qty,
   output logic [7:0] sum,
   output logic       overflow
);
   assign sum      = {1'b0, count} + {1'b0, op_qty};
   assign overflow = sum > 8'(MAX_LVL);
endmodule

// File: rtl/modulo_controlador_bandeja_rolhas.sv
// modulo_controlador_bandeja_rolhas: cork tray controller with auto-refill, operator loads and hold
module modulo_controlador_bandeja_rolhas
   import modulo_controlador_bandeja_rolhas_pkg::*;
#(
   parameter int MIN_LVL  = MIN_LVL_DEF,
   parameter int AUTO_QTY = AUTO_QTY_DEF,
   parameter int MAX_LVL  = MAX_LVL_DEF
) (
   input  logic                                clk,
   input  logic                                clr_n,
   input  logic                                enable,
   input  logic                                ve,
   modulo_controlador_bandeja_rolhas_if.slave  op,
   output logic [6:0]                          count,
   output logic                                ro,
   output logic                                min_r,
   output logic [1:0]                          mef_estado
);
   estado_t    estado;
   logic [6:0] remaining;
   logic       hold_nak;
   logic [7:0] sum;
   logic       overflow;
   logic [6:0] count_dec;
   logic [6:0] fill_next;
   logic [6:0] load_next;
   modulo_verificador_capacidade_rolhas #(.MAX_LVL(MAX_LVL)) u_cap (
      .count    (count),
      .op_qty   (op.op_qty),
      .sum      (sum),
      .overflow (overflow)
   );
   assign ro         = count == 7'd0;
   assign min_r      = count < 7'(MIN_LVL);
   assign mef_estado = estado;
   assign count_dec  = ve && !ro ? count - 7'd1 : count;
   assign fill_next  = ve || count >= 7'(MAX_LVL) ? count : count + 7'd1;
   assign load_next  = overflow ? count_dec : 7'(ve && sum != 8'd0 ? sum - 8'd1 : sum);
   // hold_nak limits HOLD to one nack per held request
   always_ff @(posedge clk or negedge clr_n)
      if (!clr_n) begin
         estado     <= IDLE;
         count      <= '0;
         remaining  <= '0;
         hold_nak   <= 1'b0;
         op.op_ack  <= 1'b0;
         op.op_nack <= 1'b0;
      end else begin
         op.op_ack  <= 1'b0;
         op.op_nack <= 1'b0;
         if (!enable && estado != HOLD) begin
            estado    <= HOLD;
            remaining <= '0;
            hold_nak  <= 1'b0;
         end else
            case (estado)
               IDLE: begin
                  count <= count_dec;
                  if (min_r) begin
                     estado    <= FILL;
                     remaining <= 7'(AUTO_QTY);
                  end else if (op.op_req)
                     estado <= LOAD;
               end
               FILL: begin
                  count     <= fill_next;
                  remaining <= remaining - 7'd1;
                  if (remaining <= 7'd1 || fill_next == 7'(MAX_LVL)) begin
                     estado    <= IDLE;
                     remaining <= '0;
                  end
               end
               LOAD: begin
                  estado     <= IDLE;
                  count      <= load_next;
                  op.op_ack  <= !overflow;
                  op.op_nack <= overflow;
               end
               HOLD: begin
                  if (enable) begin
                     estado   <= IDLE;
                     hold_nak <= 1'b0;
                  end else begin
                     op.op_nack <= op.op_req && !hold_nak;
                     hold_nak   <= op.op_req;
                  end
               end
            endcase
      end
endmodule

// File: tb/tb_modulo_controlador_bandeja_rolhas.sv
// tb_modulo_controlador_bandeja_rolhas: vector table, scoreboard and corner sequences for the tray controller
module tb_modulo_controlador_bandeja_rolhas;
   logic       clk = 1'b0;
   logic       clr_n, enable, ve;
   logic [6:0] count;
   logic       ro, min_r;
   logic [1:0] mef_estado;
   int         n_chk = 0;
   int         n_fail = 0;

   modulo_controlador_bandeja_rolhas_if op_if ();

   modulo_controlador_bandeja_rolhas dut (
      .clk        (clk),
      .clr_n      (clr_n),
      .enable     (enable),
      .ve         (ve),
      .op         (op_if),
      .count      (count),
      .ro         (ro),
      .min_r      (min_r),
      .mef_estado (mef_estado)
   );

   always #5 clk = ~clk;

   typedef struct {logic ack; logic [6:0] cnt;} resp_t;
   resp_t sb[$];

   typedef struct {
      logic en, ve, req;
      logic [6:0] qty;
      logic [6:0] cnt;
      logic [1:0] st;
      logic ack, nack;
   } vec_t;
   vec_t vt[15];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_out(input string name, input int cnt, input int st);
      chk({name, "_cnt"}, count, cnt);
      chk({name, "_st"}, mef_estado, st);
   endtask

   // every ack/nack pulse must match the oldest expected response
   always @(negedge clk)
      if (op_if.op_ack || op_if.op_nack) begin
         if (sb.size() == 0) chk("sb_pending", sb.size(), 1);
         else begin
            resp_t r;
            r = sb.pop_front();
            chk("sb_ack", op_if.op_ack, r.ack);
            chk("sb_nack", op_if.op_nack, !r.ack);
            chk("sb_cnt", count, r.cnt);
         end
      end

   initial begin
      vt[0]  = '{1, 0, 1, 79,  20, 2'b10, 0, 0};
      vt[1]  = '{1, 0, 1, 79,  99, 2'b00, 1, 0};
      vt[2]  = '{1, 0, 0, 0,   99, 2'b00, 0, 0};
      vt[3]  = '{1, 0, 1, 1,   99, 2'b10, 0, 0};
      vt[4]  = '{1, 0, 1, 1,   99, 2'b00, 0, 1};
      vt[5]  = '{1, 0, 1, 1,   99, 2'b10, 0, 0};
      vt[6]  = '{1, 0, 1, 0,   99, 2'b00, 1, 0};
      vt[7]  = '{1, 1, 1, 0,   98, 2'b10, 0, 0};
      vt[8]  = '{1, 1, 1, 1,   98, 2'b00, 1, 0};
      vt[9]  = '{1, 0, 1, 2,   98, 2'b10, 0, 0};
      vt[10] = '{1, 1, 1, 2,   97, 2'b00, 0, 1};
      vt[11] = '{1, 0, 0, 0,   97, 2'b00, 0, 0};
      vt[12] = '{1, 0, 1, 127, 97, 2'b10, 0, 0};
      vt[13] = '{1, 0, 1, 127, 97, 2'b00, 0, 1};
      vt[14] = '{1, 0, 0, 0,   97, 2'b00, 0, 0};

      clr_n = 1'b0; enable = 1'b1; ve = 1'b0;
      op_if.op_req = 1'b0; op_if.op_qty = '0;
      step();
      chk_out("rst", 0, 0);
      chk("rst_ro", ro, 1);
      chk("rst_min_r", min_r, 1);
      chk("rst_ack", op_if.op_ack, 0);
      chk("rst_nack", op_if.op_nack, 0);

      // auto-refill straight out of reset: 20 FILL cycles, 0 -> 20
      clr_n = 1'b1;
      for (int i = 1; i <= 21; i++) begin
         step();
         chk_out($sformatf("fill%0d", i), i - 1, i == 21 ? 0 : 1);
      end

      foreach (vt[i]) begin
         enable = vt[i].en; ve = vt[i].ve;
         op_if.op_req = vt[i].req; op_if.op_qty = vt[i].qty;
         if (vt[i].ack || vt[i].nack) sb.push_back('{vt[i].ack, vt[i].cnt});
         step();
         chk_out($sformatf("vec%0d", i), vt[i].cnt, vt[i].st);
         chk($sformatf("vec%0d_ack", i), op_if.op_ack, vt[i].ack);
         chk($sformatf("vec%0d_nack", i), op_if.op_nack, vt[i].nack);
      end

      // drain to 6, two more seals reach 4, then refill with ve held
      ve = 1'b1;
      for (int i = 0; i < 91; i++) step();
      chk_out("drain6", 6, 0);
      step();
      chk_out("drain5", 5, 0);
      step();
      chk_out("drain4", 4, 0);
      chk("drain4_min_r", min_r, 1);
      ve = 1'b0;
      step();
      chk_out("fill_enter", 4, 1);
      ve = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         chk_out($sformatf("fill_ve%0d", i), 4, i == 19 ? 0 : 1);
      end
      ve = 1'b0;

      // empty tray with ve: no underflow, FILL still starts
      clr_n = 1'b0; ve = 1'b1;
      step();
      clr_n = 1'b1;
      step();
      chk_out("empty_ve1", 0, 1);
      chk("empty_ve1_ro", ro, 1);
      step();
      chk_out("empty_ve2", 0, 1);
      ve = 1'b0;

      // enable drop mid-FILL, nack in HOLD, resume without refill
      clr_n = 1'b0;
      step();
      clr_n = 1'b1;
      for (int i = 0; i < 8; i++) step();
      chk_out("pre_hold", 7, 1);
      enable = 1'b0;
      step();
      chk_out("hold", 7, 3);
      op_if.op_req = 1'b1; op_if.op_qty = 7'd3; ve = 1'b1;
      sb.push_back('{1'b0, 7'd7});
      step();
      chk_out("hold_nack", 7, 3);
      chk("hold_nack_p", op_if.op_nack, 1);
      step();
      chk_out("hold_once", 7, 3);
      chk("hold_once_p", op_if.op_nack, 0);
      op_if.op_req = 1'b0;
      step();
      enable = 1'b1; ve = 1'b0;
      step();
      chk_out("resume", 7, 0);
      step();
      chk_out("no_refill", 7, 0);
      chk("no_refill_min_r", min_r, 0);
      clr_n = 1'b0;
      #1;
      chk_out("async_clr", 0, 0);
      chk("async_clr_ro", ro, 1);

      // request pending through FILL, served afterwards
      step();
      clr_n = 1'b1;
      op_if.op_req = 1'b1; op_if.op_qty = 7'd10;
      for (int i = 1; i <= 21; i++) begin
         step();
         chk_out($sformatf("pend%0d", i), i - 1, i == 21 ? 0 : 1);
         chk($sformatf("pend%0d_ack", i), op_if.op_ack | op_if.op_nack, 0);
      end
      sb.push_back('{1'b1, 7'd30});
      step();
      chk_out("pend_load", 20, 2);
      step();
      chk_out("pend_ack", 30, 0);
      chk("pend_ack_p", op_if.op_ack, 1);
      op_if.op_req = 1'b0;
      step();
      chk("pend_ack_gone", op_if.op_ack, 0);

      // reset during LOAD discards the load with no pulse
      op_if.op_req = 1'b1; op_if.op_qty = 7'd5;
      step();
      chk_out("mid_load", 30, 2);
      clr_n = 1'b0;
      #1;
      chk_out("mid_load_clr", 0, 0);
      op_if.op_req = 1'b0;
      step();
      chk("mid_load_ack", op_if.op_ack | op_if.op_nack, 0);
      clr_n = 1'b1;
      step();
      chk_out("post_clr", 0, 1);
      chk("post_clr_ack", op_if.op_ack | op_if.op_nack, 0);
      step();

      chk("sb_drained", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/modulo_controlador_bandeja_rolhas.md
MODULO_CONTROLADOR_BANDEJA_ROLHAS -- requirements
Module: modulo_controlador_bandeja_rolhas

Interface
REQ-001 SHALL have parameter MIN_LVL, default 5, auto-refill threshold (count < MIN_LVL triggers refill).
REQ-002 SHALL have parameter AUTO_QTY, default 20, corks added per auto-refill.
REQ-003 SHALL have parameter MAX_LVL, default 99, tray capacity.
REQ-004 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port clr_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  start/stop; low pauses the tray controller.
REQ-007 SHALL have port ve  input  1  sealing strobe; each high cycle consumes one cork.
REQ-008 SHALL have port op_req  input  1  operator load request, level, held until op_ack or op_nack.
REQ-009 SHALL have port op_qty  input  7  corks the operator adds; sampled in LOAD.
REQ-010 SHALL have port count  output  7  registered tray cork count, range 0..MAX_LVL.
REQ-011 SHALL have port ro  output  1  combinational, count == 0.
REQ-012 SHALL have port min_r  output  1  combinational, count < MIN_LVL.
REQ-013 SHALL have port op_ack / op_nack  output  1 each  one-cycle registered pulses.
REQ-014 SHALL have port mef_estado  output  2  current state encoding.

Function
REQ-015 SHALL implement FSM IDLE=00, FILL=01, LOAD=10, HOLD=11.
REQ-016 In any state, enable low SHALL move the FSM to HOLD next cycle. FILL in progress SHALL be aborted and the remaining counter cleared.
REQ-017 In HOLD, count SHALL be frozen. ve SHALL be ignored. op_req SHALL get op_nack once per request. enable high SHALL return the FSM to IDLE.
REQ-018 In IDLE, arbitration priority SHALL be: min_r -> FILL (remaining <= AUTO_QTY), else op_req -> LOAD, else stay.
REQ-019 In IDLE, ve SHALL decrement count by 1 when count > 0. A ve with count == 0 SHALL be ignored.
REQ-020 In FILL, each cycle SHALL increment count by 1 and decrement remaining.
REQ-021 In FILL, a ve in the same cycle SHALL leave count unchanged while remaining still decrements.
REQ-022 FILL SHALL exit to IDLE when remaining reaches 0 or count reaches MAX_LVL, whichever is first.
REQ-023 op_req during FILL SHALL stay pending, with no ack or nack, until it is arbitrated from IDLE.
REQ-024 LOAD SHALL last exactly 1 cycle and compute sum = count + op_qty at 8-bit width.
REQ-025 LOAD SHALL, if sum <= MAX_LVL: set count <= sum (sum-1 if ve that cycle) and pulse op_ack. Otherwise it SHALL pulse op_nack with count unchanged except ve decrement. In both cases next state SHALL be IDLE.
REQ-026 op_qty == 0 in LOAD SHALL be acked with no change.
REQ-027 A request still high the cycle after ack/nack SHALL be treated as new, re-arbitrated in IDLE; ack-to-next-ack minimum is 2 cycles.
REQ-028 count SHALL never exceed MAX_LVL or wrap below 0 under any input combination.

Reset
REQ-029 clr_n low SHALL asynchronously force: state IDLE, count 0, remaining 0, op_ack 0, op_nack 0. This gives ro=1 and min_r=1.
REQ-030 Release SHALL be synchronous-safe. The first active edge after release SHALL evaluate IDLE arbitration, so FILL starts immediately if enable=1.
REQ-031 Reset asserted mid-FILL or mid-LOAD SHALL discard the operation with no ack/nack pulse.

Structure
REQ-032 A shared package SHALL hold the state encoding constants and MIN_LVL/AUTO_QTY/MAX_LVL defaults for use by the display encoders and the top level.
REQ-033 One sub-module, modulo_verificador_capacidade_rolhas, SHALL be used: combinational 8-bit count+op_qty adder with output sum and overflow (sum > MAX_LVL).
REQ-034 FSM, count register and remaining counter SHALL reside in this module.

Verification
REQ-035 Reset then enable=1, no ve -> FILL for 20 cycles, count 0->20, then IDLE, mef_estado 01 then 00.
REQ-036 count=20, op_req with op_qty=79 -> LOAD, count=99, op_ack pulse. Then op_qty=1 -> op_nack, count stays 99.
REQ-037 count=6, ve pulsed 2 cycles -> count 4, min_r=1, FILL entered. ve held during FILL -> count stays 4 while remaining reaches 0 after 20 cycles.
REQ-038 count=0, ve high with enable=1 -> ro=1, count never underflows, FILL starts next cycle.
REQ-039 enable dropped at FILL cycle 7 (count 7) -> HOLD, count frozen at 7. op_req -> op_nack. enable high -> IDLE, then FILL does not start (min_r=0). clr_n pulse -> count 0.
